// File: rtl/fpu_issue_arbiter.sv
// Two-requester round-robin issue arbiter for a shared combinational FPU.
// Holds operands for a per-op latency, then presents the captured result on a valid/ready response.
module fpu_issue_arbiter #(
   parameter int unsigned TAG_W   = 5,
   parameter int unsigned LAT_ADD = 2,
   parameter int unsigned LAT_MUL = 3,
   parameter int unsigned LAT_DIV = 8
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [63:0]      req0_a,
   input  logic [63:0]      req0_b,
   input  logic [TAG_W-1:0] req0_tag,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [63:0]      req1_a,
   input  logic [63:0]      req1_b,
   input  logic [TAG_W-1:0] req1_tag,

   output logic [63:0]      fpu_operand1,
   output logic [63:0]      fpu_operand2,
   output logic [3:0]       fpu_op,
   input  logic [63:0]      fpu_result,

   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [63:0]      rsp_result,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_src,
   output logic             rsp_err,

   output logic             busy
);

   localparam int unsigned LAT_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
   localparam int unsigned LAT_MAX = (LAT_AM > LAT_DIV) ? LAT_AM : LAT_DIV;
   // Counter only ever holds LAT-1, so clog2(LAT_MAX) bits suffice.
   localparam int unsigned CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   state_e             state_q, state_d;
   logic               last_grant_q, last_grant_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [63:0]        fpu_operand1_q, fpu_operand1_d;
   logic [63:0]        fpu_operand2_q, fpu_operand2_d;
   logic [3:0]         fpu_op_q, fpu_op_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               src_q, src_d;
   logic [63:0]        rsp_result_q, rsp_result_d;
   logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
   logic               rsp_src_q, rsp_src_d;
   logic               rsp_err_q, rsp_err_d;

   logic               grant_valid;
   logic               grant_src;
   logic [3:0]         sel_op;
   logic [63:0]        sel_a;
   logic [63:0]        sel_b;
   logic [TAG_W-1:0]   sel_tag;
   logic               op_illegal;

   function automatic logic [CNT_W-1:0] lat_m1(input logic [3:0] op);
      logic [CNT_W-1:0] r;
      case (op)
         4'd0, 4'd1: r = CNT_W'(LAT_ADD - 1);
         4'd2:       r = CNT_W'(LAT_MUL - 1);
         4'd3:       r = CNT_W'(LAT_DIV - 1);
         default:    r = '0;
      endcase
      return r;
   endfunction

   // Grant is only offered in IDLE; on a tie the requester that did not win last goes next.
   always_comb begin
      grant_valid = 1'b0;
      grant_src   = 1'b0;
      if (state_q == StIdle) begin
         case ({req1_valid, req0_valid})
            2'b01: begin
               grant_valid = 1'b1;
               grant_src   = 1'b0;
            end
            2'b10: begin
               grant_valid = 1'b1;
               grant_src   = 1'b1;
            end
            2'b11: begin
               grant_valid = 1'b1;
               grant_src   = ~last_grant_q;
            end
            default: begin
               grant_valid = 1'b0;
               grant_src   = 1'b0;
            end
         endcase
      end
   end

   assign req0_ready = grant_valid & ~grant_src;
   assign req1_ready = grant_valid & grant_src;

   always_comb begin
      sel_op  = grant_src ? req1_op  : req0_op;
      sel_a   = grant_src ? req1_a   : req0_a;
      sel_b   = grant_src ? req1_b   : req0_b;
      sel_tag = grant_src ? req1_tag : req0_tag;
   end

   assign op_illegal = |fpu_op_q[3:2];

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      cnt_d          = cnt_q;
      fpu_operand1_d = fpu_operand1_q;
      fpu_operand2_d = fpu_operand2_q;
      fpu_op_d       = fpu_op_q;
      tag_d          = tag_q;
      src_d          = src_q;
      rsp_result_d   = rsp_result_q;
      rsp_tag_d      = rsp_tag_q;
      rsp_src_d      = rsp_src_q;
      rsp_err_d      = rsp_err_q;

      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               fpu_operand1_d = sel_a;
               fpu_operand2_d = sel_b;
               fpu_op_d       = sel_op;
               tag_d          = sel_tag;
               src_d          = grant_src;
               last_grant_d   = grant_src;
               cnt_d          = lat_m1(sel_op);
               state_d        = StExec;
            end
         end
         StExec: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               // Illegal codes still drive the FPU, but their result is forced to zero.
               rsp_result_d = op_illegal ? 64'd0 : fpu_result;
               rsp_tag_d    = tag_q;
               rsp_src_d    = src_q;
               rsp_err_d    = op_illegal;
               state_d      = StDone;
            end
         end
         StDone: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         last_grant_q   <= 1'b1;
         cnt_q          <= '0;
         fpu_operand1_q <= '0;
         fpu_operand2_q <= '0;
         fpu_op_q       <= '0;
         tag_q          <= '0;
         src_q          <= 1'b0;
         rsp_result_q   <= '0;
         rsp_tag_q      <= '0;
         rsp_src_q      <= 1'b0;
         rsp_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         cnt_q          <= cnt_d;
         fpu_operand1_q <= fpu_operand1_d;
         fpu_operand2_q <= fpu_operand2_d;
         fpu_op_q       <= fpu_op_d;
         tag_q          <= tag_d;
         src_q          <= src_d;
         rsp_result_q   <= rsp_result_d;
         rsp_tag_q      <= rsp_tag_d;
         rsp_src_q      <= rsp_src_d;
         rsp_err_q      <= rsp_err_d;
      end
   end

   assign fpu_operand1 = fpu_operand1_q;
   assign fpu_operand2 = fpu_operand2_q;
   assign fpu_op       = fpu_op_q;
   assign rsp_valid    = (state_q == StDone);
   assign rsp_result   = rsp_result_q;
   assign rsp_tag      = rsp_tag_q;
   assign rsp_src      = rsp_src_q;
   assign rsp_err      = rsp_err_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Bench for fpu_issue_arbiter: integer FPU stand-in, transaction-level reference model,
// directed scenarios followed by a randomized alternating-grant run.
module tb_fpu_issue_arbiter;

   localparam int unsigned TAG_W   = 5;
   localparam int unsigned LAT_ADD = 2;
   localparam int unsigned LAT_MUL = 3;
   localparam int unsigned LAT_DIV = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             req0_valid, req0_ready;
   logic [3:0]       req0_op;
   logic [63:0]      req0_a, req0_b;
   logic [TAG_W-1:0] req0_tag;
   logic             req1_valid, req1_ready;
   logic [3:0]       req1_op;
   logic [63:0]      req1_a, req1_b;
   logic [TAG_W-1:0] req1_tag;
   logic [63:0]      fpu_operand1, fpu_operand2, fpu_result;
   logic [3:0]       fpu_op;
   logic             rsp_valid, rsp_ready;
   logic [63:0]      rsp_result;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_src, rsp_err, busy;

   int               n_cmp = 0;
   int               n_err = 0;
   int               last_win;
   logic             got_src;
   logic             gap_chk;
   longint           last_acc_t;
   int               last_lat;

   fpu_issue_arbiter #(
      .TAG_W  (TAG_W),
      .LAT_ADD(LAT_ADD),
      .LAT_MUL(LAT_MUL),
      .LAT_DIV(LAT_DIV)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_op     (req0_op),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_tag    (req0_tag),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_op     (req1_op),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_tag    (req1_tag),
      .fpu_operand1(fpu_operand1),
      .fpu_operand2(fpu_operand2),
      .fpu_op      (fpu_op),
      .fpu_result  (fpu_result),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_tag     (rsp_tag),
      .rsp_src     (rsp_src),
      .rsp_err     (rsp_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Stand-in combinational FPU; illegal codes return junk the arbiter must mask.
   always_comb begin
      case (fpu_op)
         4'd0:    fpu_result = fpu_operand1 + fpu_operand2;
         4'd1:    fpu_result = fpu_operand1 - fpu_operand2;
         4'd2:    fpu_result = fpu_operand1 * fpu_operand2;
         4'd3:    fpu_result = (fpu_operand2 == 64'd0) ? '1 : fpu_operand1 / fpu_operand2;
         default: fpu_result = 64'hDEAD_BEEF_0BAD_F00D;
      endcase
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1);
   end

   function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] a,
                                              input logic [63:0] b);
      if (op == 4'd0) return a + b;
      if (op == 4'd1) return a - b;
      if (op == 4'd2) return a * b;
      if (op == 4'd3) return a / b;
      return 64'd0;
   endfunction

   function automatic int ref_lat(input logic [3:0] op);
      if (op <= 4'd1) return LAT_ADD;
      if (op == 4'd2) return LAT_MUL;
      if (op == 4'd3) return LAT_DIV;
      return 1;
   endfunction

   task automatic check1(input string name, input logic got, input logic exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0b required %0b", name, got, exp);
      end
   endtask

   task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string pfx);
      check1({pfx, "_rsp_valid"}, rsp_valid, 1'b0);
      check1({pfx, "_busy"}, busy, 1'b0);
      check64({pfx, "_opnd1"}, fpu_operand1, 64'd0);
      check64({pfx, "_opnd2"}, fpu_operand2, 64'd0);
      check64({pfx, "_fpu_op"}, 64'(fpu_op), 64'd0);
      check64({pfx, "_rsp_result"}, rsp_result, 64'd0);
      check64({pfx, "_rsp_tag"}, 64'(rsp_tag), 64'd0);
      check1({pfx, "_rsp_src"}, rsp_src, 1'b0);
      check1({pfx, "_rsp_err"}, rsp_err, 1'b0);
      check1({pfx, "_req0_ready"}, req0_ready, 1'b0);
      check1({pfx, "_req1_ready"}, req1_ready, 1'b0);
   endtask

   // Apply reset for two edges; returns positioned just after a falling edge.
   task automatic reset_dut();
      reset      = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset    = 1'b0;
      last_win = 1;
      #1;
      chk_reset_vals("reset");
   endtask

   // One full transaction: offer, accept, wait LAT, hold response, handshake.
   // Called and returns just after a falling edge with the arbiter idle.
   task automatic do_op(input logic v0, input logic [3:0] op0, input logic [63:0] a0,
                        input logic [63:0] b0, input logic [TAG_W-1:0] t0,
                        input logic v1, input logic [3:0] op1, input logic [63:0] a1,
                        input logic [63:0] b1, input logic [TAG_W-1:0] t1, input int hold);
      int               win;
      int               lat;
      logic [3:0]       eop;
      logic [63:0]      ea, eb, eres;
      logic [TAG_W-1:0] etag;
      longint           t_acc;
      req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0; req0_tag = t0;
      req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1; req1_tag = t1;
      rsp_ready  = 1'b0;
      if (v0 && v1) win = (last_win == 1) ? 0 : 1;
      else          win = v1 ? 1 : 0;
      #1;
      check1("offer_req0_ready", req0_ready, win == 0);
      check1("offer_req1_ready", req1_ready, win == 1);
      check1("offer_busy", busy, 1'b0);
      @(posedge clk);
      t_acc = $time;
      if (gap_chk) check64("accept_gap", 64'(t_acc - last_acc_t), 64'((last_lat + 2) * 10));
      last_win = win;
      eop  = (win == 1) ? op1 : op0;
      ea   = (win == 1) ? a1  : a0;
      eb   = (win == 1) ? b1  : b0;
      etag = (win == 1) ? t1  : t0;
      lat  = ref_lat(eop);
      eres = ref_result(eop, ea, eb);
      for (int c = 0; c <= lat; c++) begin
         @(negedge clk);
         req0_valid = 1'b1;
         req1_valid = 1'b1;
         #1;
         check1("exec_req0_ready", req0_ready, 1'b0);
         check1("exec_req1_ready", req1_ready, 1'b0);
         check1("exec_busy", busy, 1'b1);
         check64("exec_opnd1", fpu_operand1, ea);
         check64("exec_opnd2", fpu_operand2, eb);
         check64("exec_fpu_op", 64'(fpu_op), 64'(eop));
         check1("rsp_valid_timing", rsp_valid, c == lat);
      end
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) begin
            @(negedge clk);
            #1;
         end
         check1("done_rsp_valid", rsp_valid, 1'b1);
         check64("done_result", rsp_result, eres);
         check64("done_tag", 64'(rsp_tag), 64'(etag));
         check1("done_src", rsp_src, win == 1);
         check1("done_err", rsp_err, eop > 4'd3);
         check1("done_req0_ready", req0_ready, 1'b0);
         check1("done_req1_ready", req1_ready, 1'b0);
         if (h == hold) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            rsp_ready  = 1'b1;
         end
      end
      got_src = rsp_src;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      check1("after_hs_rsp_valid", rsp_valid, 1'b0);
      check1("after_hs_busy", busy, 1'b0);
      check64("after_hs_result_held", rsp_result, eres);
      last_acc_t = t_acc;
      last_lat   = lat;
   endtask

   initial begin
      logic [3:0]       rop0, rop1;
      logic [63:0]      ra0, rb0, ra1, rb1;
      logic [TAG_W-1:0] rt0, rt1;
      logic             exp_alt;
      gap_chk    = 1'b0;
      last_acc_t = 0;
      last_lat   = 0;
      req0_op = '0; req0_a = '0; req0_b = '0; req0_tag = '0;
      req1_op = '0; req1_a = '0; req1_b = '0; req1_tag = '0;
      reset_dut();

      // Single add from requester 0.
      do_op(1'b1, 4'd0, 64'd7, 64'd5, 5'd3, 1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 0);
      check64("add_result", rsp_result, 64'd12);

      // Tie-break after reset favours requester 0, then alternates.
      reset_dut();
      do_op(1'b1, 4'd2, 64'd6, 64'd7, 5'd1, 1'b1, 4'd1, 64'd10, 64'd4, 5'd2, 0);
      check1("tie1_src", got_src, 1'b0);
      check64("tie1_result", rsp_result, 64'd42);
      do_op(1'b1, 4'd2, 64'd6, 64'd7, 5'd1, 1'b1, 4'd1, 64'd10, 64'd4, 5'd2, 0);
      check1("tie2_src", got_src, 1'b1);
      check64("tie2_result", rsp_result, 64'd6);
      do_op(1'b1, 4'd0, 64'd20, 64'd22, 5'd4, 1'b1, 4'd1, 64'd10, 64'd4, 5'd2, 0);
      check1("tie3_src", got_src, 1'b0);

      // Divide with a stalled consumer.
      do_op(1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 1'b1, 4'd3, 64'd100, 64'd8, 5'd11, 5);
      check64("div_result", rsp_result, 64'd12);

      // Illegal opcode, then a legal op clears the error flag.
      do_op(1'b1, 4'd9, 64'd1, 64'd1, 5'd7, 1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 0);
      check1("illegal_err", rsp_err, 1'b1);
      check64("illegal_tag", 64'(rsp_tag), 64'd7);
      do_op(1'b1, 4'd1, 64'd9, 64'd4, 5'd8, 1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 0);
      check1("legal_after_illegal_err", rsp_err, 1'b0);

      // Reset three cycles into a divide discards it.
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_op = 4'd3; req1_a = 64'd1000; req1_b = 64'd10; req1_tag = 5'd9;
      #1;
      check1("rst_div_accept", req1_ready, 1'b1);
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req1_valid = 1'b0;
         #1;
         check1("rst_div_busy", busy, 1'b1);
         check1("rst_div_no_rsp", rsp_valid, 1'b0);
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset    = 1'b0;
      last_win = 1;
      #1;
      chk_reset_vals("midrst");
      for (int c = 0; c < int'(LAT_DIV) + 2; c++) begin
         @(negedge clk);
         #1;
         check1("midrst_no_rsp", rsp_valid, 1'b0);
         check1("midrst_idle", busy, 1'b0);
      end
      do_op(1'b1, 4'd0, 64'd30, 64'd12, 5'd5, 1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 0);
      check64("post_rst_add", rsp_result, 64'd42);

      // Randomized back-to-back traffic with both requesters always valid.
      for (int i = 0; i < 10; i++) begin
         rop0 = 4'($urandom_range(0, 3));
         rop1 = 4'($urandom_range(0, 3));
         ra0  = {$urandom(), $urandom()};
         rb0  = {$urandom(), $urandom()} | 64'd1;
         ra1  = {$urandom(), $urandom()};
         rb1  = {$urandom(), $urandom()} | 64'd1;
         rt0  = TAG_W'($urandom());
         rt1  = TAG_W'($urandom());
         exp_alt = (last_win == 1) ? 1'b0 : 1'b1;
         gap_chk = (i > 0);
         do_op(1'b1, rop0, ra0, rb0, rt0, 1'b1, rop1, ra1, rb1, rt1, 0);
         check1("alt_src", got_src, exp_alt);
      end
      gap_chk = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
